// File: rtl/core_run_controller.sv
// Run-control sequencer: program load into IMEM, PC gating (run/halt/step), EBREAK detect, retire count.
// Optional RUN-cycle watchdog is compiled in with `define WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for a program load or a start
// LOAD   | accepting program words into IMEM
// RUN    | PC advances every cycle until halt_req, EBREAK or watchdog
// STEP   | one instruction while halted, then back to HALTED
// HALTED | PC frozen; step or start to continue
module core_run_controller #(
  parameter int IMEM_WORDS = 256,
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       instruction,
  output logic              pc_en,
  output logic              pc_clear,
  output logic [2:0]        state,
  output logic [1:0]        halt_cause,
  output logic [31:0]       retired,
  output logic              load_ovf
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [31:0]       EBREAK    = 32'h00100073;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              loaded_q, loaded_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              pc_clear_q, pc_clear_d;
  logic [1:0]        halt_cause_q, halt_cause_d;
  logic [31:0]       retired_q, retired_d;
  logic              load_ovf_q, load_ovf_d;

  logic is_ebreak;
  logic accept;
  logic wdog_clr;
  logic wdog_hit;

  assign is_ebreak  = (instruction == EBREAK);
  assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept     = load_valid && load_ready;
  assign pc_en      = ((state_q == S_RUN) || (state_q == S_STEP)) && !is_ebreak;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    loaded_d     = loaded_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    pc_clear_d   = 1'b0;
    halt_cause_d = halt_cause_q;
    retired_d    = retired_q;
    load_ovf_d   = load_ovf_q;
    wdog_clr     = 1'b0;

    if (pc_en && (retired_q != 32'hFFFF_FFFF)) retired_d = retired_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // A beat in IDLE always starts a fresh program at address 0.
          imem_we_d    = 1'b1;
          imem_waddr_d = '0;
          imem_wdata_d = load_data;
          wcnt_d       = ONE_ADDR;
          loaded_d     = load_last;
          state_d      = load_last ? S_IDLE : S_LOAD;
        end else if (start && loaded_q) begin
          pc_clear_d   = 1'b1;
          retired_d    = '0;
          halt_cause_d = 2'd0;
          wdog_clr     = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_LOAD: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_waddr_d = wcnt_q;
          imem_wdata_d = load_data;
          wcnt_d       = wcnt_q + ONE_ADDR;
          if (load_last || (wcnt_q == LAST_ADDR)) begin
            state_d  = S_IDLE;
            loaded_d = 1'b1;
            if (!load_last) load_ovf_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (halt_req) begin
          halt_cause_d = 2'd1;
          state_d      = S_HALTED;
        end else if (is_ebreak) begin
          halt_cause_d = 2'd2;
          state_d      = S_HALTED;
        end else if (wdog_hit) begin
          halt_cause_d = 2'd3;
          state_d      = S_HALTED;
        end
      end
      S_STEP: begin
        if (is_ebreak) halt_cause_d = 2'd2;
        state_d = S_HALTED;
      end
      S_HALTED: begin
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (step) begin
          state_d = S_STEP;
        end else if (start) begin
          halt_cause_d = 2'd0;
          wdog_clr     = 1'b1;
          state_d      = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      loaded_q     <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      pc_clear_q   <= 1'b0;
      halt_cause_q <= 2'd0;
      retired_q    <= '0;
      load_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      loaded_q     <= loaded_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      pc_clear_q   <= pc_clear_d;
      halt_cause_q <= halt_cause_d;
      retired_q    <= retired_d;
      load_ovf_q   <= load_ovf_d;
    end
  end

`ifdef WATCHDOG_EN
  localparam logic [31:0] WDOG_LIMIT = 32'(MAX_CYCLES - 1);

  logic [31:0] wdog_q, wdog_d;

  assign wdog_hit = (state_q == S_RUN) && (wdog_q == WDOG_LIMIT);

  always_comb begin
    wdog_d = wdog_q;
    if (wdog_clr)                wdog_d = '0;
    else if (state_q == S_RUN)   wdog_d = wdog_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_wdog;

  assign wdog_hit    = 1'b0;
  assign unused_wdog = wdog_clr ^ (MAX_CYCLES == 0);
`endif

  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign pc_clear   = pc_clear_q;
  assign state      = state_q;
  assign halt_cause = halt_cause_q;
  assign retired    = retired_q;
  assign load_ovf   = load_ovf_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Self-checking bench for core_run_controller: randomized loads, runs, halts and steps
// against a scenario-level model of expected state, halt cause and retire count.
module tb_core_run_controller;

  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, step, halt_req;
  logic        load_valid, load_last;
  logic        load_ready;
  logic [31:0] load_data;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] instruction;
  logic        pc_en, pc_clear;
  logic [2:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] retired;
  logic        load_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  int          exp_retired;
  logic [1:0]  exp_cause;

  core_run_controller #(.IMEM_WORDS(256), .ADDR_W(8), .MAX_CYCLES(20)) dut (
    .clk(clk), .reset(reset_n), .start(start), .step(step), .halt_req(halt_req),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .instruction(instruction), .pc_en(pc_en),
    .pc_clear(pc_clear), .state(state), .halt_cause(halt_cause),
    .retired(retired), .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rand_insn();
    logic [31:0] v;
    v = $urandom;
    if (v == EBREAK) v = 32'h0000_0013;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; step = 0; halt_req = 0;
    load_valid = 0; load_last = 0; load_data = 0;
    instruction = rand_insn();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (state !== 3'd0) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", imem_we); else n_pass++;
    n_checks++; if (imem_waddr !== 8'd0) $display("FAIL rst_waddr: got %0d want 0", imem_waddr); else n_pass++;
    n_checks++; if (imem_wdata !== 32'd0) $display("FAIL rst_wdata: got %h want 0", imem_wdata); else n_pass++;
    n_checks++; if (pc_clear !== 1'b0) $display("FAIL rst_pc_clear: got %b want 0", pc_clear); else n_pass++;
    n_checks++; if (halt_cause !== 2'd0) $display("FAIL rst_cause: got %0d want 0", halt_cause); else n_pass++;
    n_checks++; if (retired !== 32'd0) $display("FAIL rst_retired: got %0d want 0", retired); else n_pass++;
    n_checks++; if (load_ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", load_ovf); else n_pass++;
    n_checks++; if (load_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", load_ready); else n_pass++;
    reset_n = 1;
    tick();
  endtask

  task automatic test_load(input int n);
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 0;
        tick();
        n_checks++; if (imem_we !== 1'b0) $display("FAIL load_gap_we: got %b want 0", imem_we); else n_pass++;
      end
      d = $urandom;
      load_valid = 1; load_data = d; load_last = (k == n - 1);
      tick();
      load_valid = 0; load_last = 0;
      n_checks++; if (imem_we !== 1'b1) $display("FAIL load_we[%0d]: got %b want 1", k, imem_we); else n_pass++;
      n_checks++; if (imem_waddr !== 8'(k)) $display("FAIL load_waddr[%0d]: got %0d want %0d", k, imem_waddr, k); else n_pass++;
      n_checks++; if (imem_wdata !== d) $display("FAIL load_wdata[%0d]: got %h want %h", k, imem_wdata, d); else n_pass++;
      n_checks++; if (state !== ((k == n - 1) ? 3'd0 : 3'd1)) $display("FAIL load_state[%0d]: got %0d", k, state); else n_pass++;
    end
    tick();
    n_checks++; if (imem_we !== 1'b0) $display("FAIL load_end_we: got %b want 0", imem_we); else n_pass++;
  endtask

  task automatic test_start_run(input int cycles);
    start = 1;
    tick();
    start = 0;
    exp_retired = 0; exp_cause = 2'd0;
    n_checks++; if (pc_clear !== 1'b1) $display("FAIL start_pc_clear: got %b want 1", pc_clear); else n_pass++;
    n_checks++; if (state !== 3'd2) $display("FAIL start_state: got %0d want 2", state); else n_pass++;
    n_checks++; if (retired !== 32'd0) $display("FAIL start_retired: got %0d want 0", retired); else n_pass++;
    n_checks++; if (halt_cause !== 2'd0) $display("FAIL start_cause: got %0d want 0", halt_cause); else n_pass++;
    for (int c = 0; c < cycles; c++) begin
      instruction = rand_insn();
      #1;
      n_checks++; if (pc_en !== 1'b1) $display("FAIL run_pc_en[%0d]: got %b want 1", c, pc_en); else n_pass++;
      tick();
      if (c == 0) begin
        n_checks++; if (pc_clear !== 1'b0) $display("FAIL pc_clear_width: got %b want 0", pc_clear); else n_pass++;
      end
    end
    exp_retired += cycles;
    n_checks++; if (retired !== 32'(exp_retired)) $display("FAIL run_retired: got %0d want %0d", retired, exp_retired); else n_pass++;
    n_checks++; if (state !== 3'd2) $display("FAIL run_state: got %0d want 2", state); else n_pass++;
  endtask

  task automatic test_ebreak();
    instruction = EBREAK;
    #1;
    n_checks++; if (pc_en !== 1'b0) $display("FAIL ebreak_pc_en: got %b want 0", pc_en); else n_pass++;
    tick();
    instruction = rand_insn();
    exp_cause = 2'd2;
    n_checks++; if (state !== 3'd4) $display("FAIL ebreak_state: got %0d want 4", state); else n_pass++;
    n_checks++; if (halt_cause !== exp_cause) $display("FAIL ebreak_cause: got %0d want 2", halt_cause); else n_pass++;
    n_checks++; if (retired !== 32'(exp_retired)) $display("FAIL ebreak_retired: got %0d want %0d", retired, exp_retired); else n_pass++;
  endtask

  task automatic test_step(input bit with_start);
    int pulses;
    instruction = rand_insn();
    step = 1; start = with_start;
    tick();
    step = 0; start = 0;
    n_checks++; if (state !== 3'd3) $display("FAIL step_state: got %0d want 3 (start=%0d)", state, with_start); else n_pass++;
    pulses = 32'(pc_en);
    tick();
    n_checks++; if (state !== 3'd4) $display("FAIL step_return: got %0d want 4", state); else n_pass++;
    pulses += 32'(pc_en);
    repeat (3) begin
      tick();
      pulses += 32'(pc_en);
    end
    exp_retired++;
    n_checks++; if (pulses != 1) $display("FAIL step_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (retired !== 32'(exp_retired)) $display("FAIL step_retired: got %0d want %0d", retired, exp_retired); else n_pass++;
    n_checks++; if (halt_cause !== exp_cause) $display("FAIL step_cause: got %0d want %0d", halt_cause, exp_cause); else n_pass++;
    n_checks++; if (state !== 3'd4) $display("FAIL step_idle_state: got %0d want 4", state); else n_pass++;
  endtask

  task automatic test_resume_halt(input int k);
    halt_req = 1; start = 1;
    tick();
    halt_req = 0; start = 0;
    n_checks++; if (state !== 3'd4) $display("FAIL halt_over_start: got %0d want 4", state); else n_pass++;
    start = 1;
    tick();
    start = 0;
    exp_cause = 2'd0;
    n_checks++; if (state !== 3'd2) $display("FAIL resume_state: got %0d want 2", state); else n_pass++;
    n_checks++; if (pc_clear !== 1'b0) $display("FAIL resume_pc_clear: got %b want 0", pc_clear); else n_pass++;
    n_checks++; if (halt_cause !== exp_cause) $display("FAIL resume_cause: got %0d want 0", halt_cause); else n_pass++;
    for (int c = 0; c < k; c++) begin
      instruction = rand_insn();
      #1;
      n_checks++; if (pc_en !== 1'b1) $display("FAIL resume_pc_en[%0d]: got %b want 1", c, pc_en); else n_pass++;
      tick();
    end
    halt_req = 1;
    #1;
    n_checks++; if (pc_en !== 1'b1) $display("FAIL halt_cycle_pc_en: got %b want 1", pc_en); else n_pass++;
    tick();
    halt_req = 0;
    exp_retired += k + 1;
    exp_cause = 2'd1;
    n_checks++; if (state !== 3'd4) $display("FAIL halt_state: got %0d want 4", state); else n_pass++;
    n_checks++; if (halt_cause !== exp_cause) $display("FAIL halt_cause: got %0d want 1", halt_cause); else n_pass++;
    n_checks++; if (retired !== 32'(exp_retired)) $display("FAIL halt_retired: got %0d want %0d", retired, exp_retired); else n_pass++;
    n_checks++; if (pc_en !== 1'b0) $display("FAIL halted_pc_en: got %b want 0", pc_en); else n_pass++;
  endtask

  task automatic test_resume_ebreak();
    instruction = EBREAK;
    start = 1;
    tick();
    start = 0;
    n_checks++; if (state !== 3'd2) $display("FAIL reebreak_run: got %0d want 2", state); else n_pass++;
    n_checks++; if (pc_en !== 1'b0) $display("FAIL reebreak_pc_en: got %b want 0", pc_en); else n_pass++;
    tick();
    instruction = rand_insn();
    exp_cause = 2'd2;
    n_checks++; if (state !== 3'd4) $display("FAIL reebreak_state: got %0d want 4", state); else n_pass++;
    n_checks++; if (halt_cause !== exp_cause) $display("FAIL reebreak_cause: got %0d want 2", halt_cause); else n_pass++;
    n_checks++; if (retired !== 32'(exp_retired)) $display("FAIL reebreak_retired: got %0d want %0d", retired, exp_retired); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int          bad_addr;
    int          bad_other;
    bad_addr = 0; bad_other = 0;
    for (int k = 0; k <= 256; k++) begin
      d = $urandom;
      load_valid = 1; load_data = d; load_last = 0;
      tick();
      load_valid = 0;
      if (imem_waddr !== 8'(k % 256) || imem_wdata !== d || imem_we !== 1'b1) bad_addr++;
      if (load_ovf !== (k >= 255) || state !== ((k == 255) ? 3'd0 : 3'd1)) bad_other++;
    end
    n_checks++; if (bad_addr != 0) $display("FAIL ovf_writes: got %0d bad beats want 0", bad_addr); else n_pass++;
    n_checks++; if (bad_other != 0) $display("FAIL ovf_flag_state: got %0d bad beats want 0", bad_other); else n_pass++;
    n_checks++; if (imem_waddr !== 8'd0) $display("FAIL ovf_wrap_addr: got %0d want 0", imem_waddr); else n_pass++;
    n_checks++; if (load_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", load_ovf); else n_pass++;
    d = $urandom;
    load_valid = 1; load_data = d; load_last = 1;
    tick();
    load_valid = 0; load_last = 0;
    n_checks++; if (imem_waddr !== 8'd1) $display("FAIL ovf_last_addr: got %0d want 1", imem_waddr); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL ovf_last_state: got %0d want 0", state); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    test_start_run($urandom_range(2, 6));
    #2;
    reset_n = 0;
    #1;
    n_checks++; if (state !== 3'd0) $display("FAIL arst_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (imem_waddr !== 8'd0) $display("FAIL arst_waddr: got %0d want 0", imem_waddr); else n_pass++;
    n_checks++; if (imem_wdata !== 32'd0) $display("FAIL arst_wdata: got %h want 0", imem_wdata); else n_pass++;
    n_checks++; if (retired !== 32'd0) $display("FAIL arst_retired: got %0d want 0", retired); else n_pass++;
    n_checks++; if (load_ovf !== 1'b0) $display("FAIL arst_ovf: got %b want 0", load_ovf); else n_pass++;
    n_checks++; if (pc_en !== 1'b0) $display("FAIL arst_pc_en: got %b want 0", pc_en); else n_pass++;
    tick();
    reset_n = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    n_checks++; if (state !== 3'd0) $display("FAIL unloaded_start_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (pc_clear !== 1'b0) $display("FAIL unloaded_pc_clear: got %b want 0", pc_clear); else n_pass++;
    test_load($urandom_range(1, 5));
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog();
    start = 1;
    tick();
    start = 0;
    repeat (19) begin
      instruction = rand_insn();
      tick();
    end
    n_checks++; if (state !== 3'd2) $display("FAIL wdog_early: got %0d want 2", state); else n_pass++;
    tick();
    n_checks++; if (state !== 3'd4) $display("FAIL wdog_state: got %0d want 4", state); else n_pass++;
    n_checks++; if (halt_cause !== 2'd3) $display("FAIL wdog_cause: got %0d want 3", halt_cause); else n_pass++;
    n_checks++; if (retired !== 32'd20) $display("FAIL wdog_retired: got %0d want 20", retired); else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset_n = 0;
    exp_retired = 0;
    exp_cause = 2'd0;
    test_reset();
    test_load(4);
    test_start_run(10);
    test_ebreak();
    test_step(1'b0);
    test_step(1'b1);
    test_resume_halt($urandom_range(2, 12));
    test_resume_ebreak();
    repeat (3) begin
      test_reset();
      test_load($urandom_range(1, 8));
      test_start_run($urandom_range(3, 12));
      test_ebreak();
      test_step(1'($urandom_range(0, 1)));
      test_resume_halt($urandom_range(0, 12));
    end
    test_reset();
    test_overflow();
    test_reset_mid_run();
`ifdef WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_run_controller.md
Name: core_run_controller

Overview:
Run-control sequencer for the single-cycle RISC-V datapath.
- Loads program words into instruction memory through a valid/ready stream.
- Issues a PC clear, then gates PC update per cycle (run, halt, single-step).
- Detects EBREAK and counts retired instructions.
- Sits between the host/testbench and the datapath's PC enable and instruction-memory write port.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words
ADDR_W, 8, word-address width (log2 IMEM_WORDS)
MAX_CYCLES, 100000, watchdog limit in RUN cycles (used only with WATCHDOG_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  pulse: begin (IDLE) or resume (HALTED) execution
step  input  1  pulse: execute one instruction while HALTED
halt_req  input  1  pulse: stop execution
load_valid  input  1  program word valid
load_ready  output  1  controller can accept a program word
load_data  input  32  program word
load_last  input  1  marks final program word
imem_we  output  1  instruction-memory write enable
imem_waddr  output  ADDR_W  instruction-memory word address
imem_wdata  output  32  instruction-memory write data
instruction  input  32  current instruction from the datapath
pc_en  output  1  PC may advance this cycle
pc_clear  output  1  one-cycle PC reset to 0
state  output  3  IDLE=0, LOAD=1, RUN=2, STEP=3, HALTED=4
halt_cause  output  2  0 none, 1 halt_req, 2 EBREAK, 3 watchdog
retired  output  32  retired-instruction count
load_ovf  output  1  sticky: program exceeded IMEM_WORDS

Behaviour:
Reset (reset=0, async):
- state=IDLE; imem_we=0; imem_waddr=0; imem_wdata=0; pc_clear=0.
- halt_cause=0; retired=0; load_ovf=0; internal loaded flag=0; word counter=0.

Load path:
- load_ready=1 in IDLE and LOAD, else 0. A beat is accepted when load_valid && load_ready.
- Beat accepted in IDLE: word counter cleared to 0, loaded cleared, state→LOAD (or stays IDLE if load_last).
- Per accepted beat: next cycle imem_we=1, imem_waddr=counter, imem_wdata=load_data; counter++. Registered, 1-cycle latency.
- Beat with load_last, or beat at counter==IMEM_WORDS-1: state→IDLE, loaded=1. In the overflow case (not last), load_ovf=1 and further beats are accepted as a new load from address 0.

Run control:
- is_ebreak = (instruction==32'h00100073).
- pc_en = (state==RUN || state==STEP) && !is_ebreak (combinational).
- IDLE + start + loaded: pc_clear=1 for the next cycle, retired=0, halt_cause=0, state→RUN. start ignored if !loaded.
- IDLE priority: load_valid beats start.
- RUN: retired++ every cycle with pc_en=1.
  - halt_req → HALTED, cause 1; pc_en drops from the next cycle.
  - is_ebreak → HALTED, cause 2; PC holds at the EBREAK address and it is not counted.
- HALTED: priority halt_req (no-op) > step > start.
  - step → STEP: exactly one cycle, pc_en=1 unless EBREAK, then back to HALTED.
  - start → RUN without pc_clear; halt_cause cleared.
  - Resuming at an EBREAK re-halts after one cycle with cause 2 and no retire.
- STEP ignores start/step/halt_req.
- retired saturates at 32'hFFFFFFFF.
- Reset asserted mid-LOAD/RUN: immediate return to reset values. The program must be reloaded (loaded=0).

Optional Feature:
WATCHDOG_EN:
- Defined: a 32-bit RUN-cycle counter, cleared on entry to RUN. When it reaches MAX_CYCLES-1 while in RUN, next state=HALTED, halt_cause=3. halt_req/EBREAK in the same cycle take priority (causes 1/2).
- Undefined: counter absent, cause 3 never produced.

Test Plan:
- Load 4 words (last on 4th) → imem_we pulses at addresses 0..3 with the data, each one cycle after its handshake; state returns to 0.
- start after load → pc_clear high one cycle, state=2; 10 non-EBREAK cycles → retired=10.
- instruction=32'h00100073 in RUN → pc_en=0 that cycle, state=4, halt_cause=2, retired unchanged.
- HALTED + step, then 3 idle cycles → exactly one pc_en pulse, retired+1, state 4→3→4.
- step and start asserted together in HALTED → STEP taken; start ignored.
- 257 beats, no last, IMEM_WORDS=256 → load_ovf=1 after beat 256; beat 257 written at address 0.
- reset low mid-RUN → outputs return to reset values asynchronously; start then ignored until a reload.
- WATCHDOG_EN, MAX_CYCLES=20 → HALTED with cause 3 after 20 RUN cycles.
